// File: rtl/lemon_ifu.sv
// lemon_ifu -- single-outstanding instruction fetch unit.
//
// Purpose:
//   Walks a PC, issues one fetch request at a time, registers the returned
//   instruction and holds it until downstream takes it.  Redirects
//   (branch/jump) take priority over every other transition.  A request
//   already in flight when a redirect hits is marked stale, and its
//   response is dropped when it arrives.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   req_valid/req_ready       fetch request handshake, req_addr = current PC
//   resp_valid/resp_data      memory response (one per accepted request)
//   inst_valid/inst_ready     downstream handshake, inst + inst_pc held stable
//   redirect_valid/_pc        redirect the fetch stream
//   fetch_cnt                 instructions handed downstream (wraps)
//   fault                     misaligned-redirect fault
//
// Configuration:
//   IFU_MISALIGN_CHECK_EN  defined: a redirect with redirect_pc[1:0] != 0
//                          parks the unit in FAULT until an aligned redirect.
//                          undefined: the low two target bits are cleared and
//                          fault is tied 0.

module lemon_ifu #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int              ILEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [ILEN-1:0] resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] fetch_cnt,
  output logic            fault
);

  localparam logic [XLEN-1:0] STEP = XLEN'(ILEN / 8);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
`ifdef IFU_MISALIGN_CHECK_EN
    ,S_FAULT = 2'd3
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
  logic            stale_q, stale_d;

  // redir_ok: redirect that actually loads a new PC.
  // redir_state: where a redirect sends the FSM (REQ, or FAULT if misaligned).
  logic [XLEN-1:0] redir_tgt;
  logic            redir_ok;
  state_t          redir_state;
  logic            req_fire;

`ifdef IFU_MISALIGN_CHECK_EN
  assign redir_tgt   = redirect_pc;
  assign redir_ok    = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redir_state = redir_ok ? S_REQ : S_FAULT;
  assign fault       = (state_q == S_FAULT);
`else
  assign redir_tgt   = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
  assign redir_ok    = redirect_valid;
  assign redir_state = S_REQ;
  assign fault       = 1'b0;
`endif

  // A stale request is still in flight while stale_q is set, so no new
  // request may go out until its response has been absorbed.
  assign req_valid  = (state_q == S_REQ) && !stale_q;
  assign req_fire   = req_valid && req_ready;
  assign req_addr   = pc_q;
  assign inst_valid = (state_q == S_HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign fetch_cnt  = fetch_cnt_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    fetch_cnt_d = fetch_cnt_q;
    stale_d     = stale_q;

    // The discarded response can land in any state; absorbing it clears stale.
    if (resp_valid && stale_q) stale_d = 1'b0;

    case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          state_d = redir_state;
          if (redir_ok) pc_d = redir_tgt;
          if (req_fire) stale_d = 1'b1;
        end else if (req_fire) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          if (redir_ok) pc_d = redir_tgt;
          if (resp_valid) begin
            // Response for the old PC arrives with the redirect: drop it now.
            stale_d = 1'b0;
            state_d = redir_state;
          end else begin
            stale_d = 1'b1;
            state_d = redir_ok ? S_WAIT : redir_state;
          end
        end else if (resp_valid) begin
          if (stale_q) begin
            state_d = S_REQ;
          end else begin
            inst_d    = resp_data;
            inst_pc_d = pc_q;
            state_d   = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (inst_ready) fetch_cnt_d = fetch_cnt_q + XLEN'(1);
        if (redirect_valid) begin
          state_d = redir_state;
          if (redir_ok) pc_d = redir_tgt;
        end else if (inst_ready) begin
          pc_d    = pc_q + STEP;
          state_d = S_REQ;
        end
      end

`ifdef IFU_MISALIGN_CHECK_EN
      S_FAULT: begin
        if (redir_ok) begin
          pc_d    = redir_tgt;
          state_d = S_REQ;
        end
      end
`endif

      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      inst_pc_q   <= '0;
      fetch_cnt_q <= '0;
      stale_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      stale_q     <= stale_d;
    end
  end

endmodule

// File: tb/tb_lemon_ifu.sv
module tb_lemon_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_ready = 1'b0, resp_valid = 1'b0, inst_ready = 1'b0, redirect_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic [63:0] redirect_pc = '0;

  logic        req_valid, inst_valid, fault;
  logic [63:0] req_addr, inst_pc, fetch_cnt;
  logic [31:0] inst;
  logic        w_req_valid, w_inst_valid, w_fault;
  logic [63:0] w_req_addr, w_inst_pc, w_fetch_cnt;
  logic [31:0] w_inst;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lemon_ifu u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_cnt(fetch_cnt), .fault(fault)
  );

  // Same stimulus, PC starting just below the top of the address space.
  lemon_ifu #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .req_valid(w_req_valid), .req_ready(req_ready), .req_addr(w_req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .inst_valid(w_inst_valid), .inst_ready(inst_ready),
    .inst(w_inst), .inst_pc(w_inst_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_cnt(w_fetch_cnt), .fault(w_fault)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_ready = 0; resp_valid = 0; resp_data = '0; inst_ready = 0;
    redirect_valid = 0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_fetch_cnt", fetch_cnt, 0);
    chk("rst_fault", fault, 0);
    rst = 1'b0;
    #1;
    chk("rel_req_valid", req_valid, 1);
    chk("rel_req_addr", req_addr, 64'h8000_0000);
    chk("rel_wrap_req_addr", w_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rr, rv;
    logic [31:0] rd;
    logic        ir, rdv;
    logic [63:0] rpc;
    logic        e_reqv;
    logic [63:0] e_addr;
    logic        e_instv;
    logic [31:0] e_inst;
    logic [63:0] e_ipc;
    logic [63:0] e_cnt;
  } vec_t;

  localparam logic [63:0] A  = 64'h8000_0000;
  localparam logic [31:0] D1 = 32'h0010_0093, D2 = 32'h0020_0113, D3 = 32'h0030_0193,
                          D4 = 32'h0040_0213, DX = 32'hDEAD_BEEF;
  vec_t tv[26];

  // ---------------- behavioural reference ----------------
  // Spec-level view: a request may go out only when nothing is in flight,
  // nothing is held for downstream, and the unit is not faulted.
  logic [63:0] m_pc, m_cnt, m_ipc;
  logic [31:0] m_inst;
  logic        m_hold, m_outst, m_stale, m_fault;
  logic        mem_busy;
  int          mem_wait;

  task automatic model_reset();
    m_pc = 64'h8000_0000; m_cnt = '0; m_ipc = '0; m_inst = '0;
    m_hold = 0; m_outst = 0; m_stale = 0; m_fault = 0;
    mem_busy = 0; mem_wait = 0;
  endtask

  task automatic model_step();
    logic rv_pre, arriving, new_issue, consumed, bad;
    logic [63:0] tgt;
    rv_pre    = !m_hold && !m_outst && !m_fault;
    arriving  = m_outst && resp_valid;
    new_issue = rv_pre && req_ready;
    consumed  = m_hold && inst_ready;
`ifdef IFU_MISALIGN_CHECK_EN
    bad = (redirect_pc[1:0] != 2'b00);
    tgt = redirect_pc;
`else
    bad = 1'b0;
    tgt = redirect_pc & ~64'h3;
`endif
    if (consumed) m_cnt = m_cnt + 64'd1;
    if (redirect_valid) begin
      if (arriving) begin m_outst = 0; m_stale = 0; end
      else if (m_outst) m_stale = 1;
      if (new_issue) begin m_outst = 1; m_stale = 1; end
      m_hold = 0;
      if (bad) m_fault = 1;
      else begin m_fault = 0; m_pc = tgt; end
    end else begin
      if (arriving) begin
        if (!m_stale) begin m_hold = 1; m_inst = resp_data; m_ipc = m_pc; end
        m_outst = 0; m_stale = 0;
      end
      if (new_issue) begin m_outst = 1; m_stale = 0; end
      if (consumed) begin m_pc = m_pc + 64'd4; m_hold = 0; end
    end
    // memory: one response, 1..3 cycles after acceptance
    if (resp_valid) mem_busy = 0;
    else if (mem_busy) mem_wait--;
    if (new_issue) begin mem_busy = 1; mem_wait = $urandom_range(0, 2); end
  endtask

  initial begin
    logic [63:0] rp;

    //          rr rv rd  ir rdv rpc           | reqv addr              instv inst ipc              cnt
    tv[0]  = '{1, 0, 0,  0, 0, 0,              0, A,                 0, 0,  0,                0};
    tv[1]  = '{0, 1, D1, 0, 0, 0,              0, A,                 1, D1, A,                0};
    tv[2]  = '{0, 0, 0,  1, 0, 0,              1, A+4,               0, D1, A,                1};
    tv[3]  = '{0, 0, 0,  0, 0, 0,              1, A+4,               0, D1, A,                1};
    tv[4]  = '{1, 0, 0,  0, 0, 0,              0, A+4,               0, D1, A,                1};
    tv[5]  = '{0, 0, 0,  0, 0, 0,              0, A+4,               0, D1, A,                1};
    tv[6]  = '{0, 1, D2, 0, 0, 0,              0, A+4,               1, D2, A+4,              1};
    for (int k = 7; k <= 11; k++)
      tv[k] = '{1, 0, 0,  0, 0, 0,             0, A+4,               1, D2, A+4,              1};
    tv[12] = '{0, 0, 0,  1, 0, 0,              1, A+8,               0, D2, A+4,              2};
    tv[13] = '{1, 0, 0,  0, 0, 0,              0, A+8,               0, D2, A+4,              2};
    tv[14] = '{0, 0, 0,  0, 1, 64'h8000_1000,  0, 64'h8000_1000,     0, D2, A+4,              2};
    tv[15] = '{0, 1, DX, 0, 0, 0,              1, 64'h8000_1000,     0, D2, A+4,              2};
    tv[16] = '{1, 0, 0,  0, 0, 0,              0, 64'h8000_1000,     0, D2, A+4,              2};
    tv[17] = '{0, 1, D3, 0, 0, 0,              0, 64'h8000_1000,     1, D3, 64'h8000_1000,    2};
    tv[18] = '{0, 0, 0,  1, 1, 64'h8000_2000,  1, 64'h8000_2000,     0, D3, 64'h8000_1000,    3};
    tv[19] = '{1, 0, 0,  0, 1, 64'h8000_3000,  0, 64'h8000_3000,     0, D3, 64'h8000_1000,    3};
    tv[20] = '{0, 1, DX, 0, 0, 0,              1, 64'h8000_3000,     0, D3, 64'h8000_1000,    3};
    tv[21] = '{1, 0, 0,  0, 0, 0,              0, 64'h8000_3000,     0, D3, 64'h8000_1000,    3};
    tv[22] = '{0, 1, D4, 0, 0, 0,              0, 64'h8000_3000,     1, D4, 64'h8000_3000,    3};
    tv[23] = '{0, 0, 0,  0, 1, 64'h8000_4000,  1, 64'h8000_4000,     0, D4, 64'h8000_3000,    3};
    tv[24] = '{1, 0, 0,  0, 0, 0,              0, 64'h8000_4000,     0, D4, 64'h8000_3000,    3};
    tv[25] = '{0, 1, DX, 0, 1, 64'h8000_5000,  1, 64'h8000_5000,     0, D4, 64'h8000_3000,    3};

    do_reset();

    for (int i = 0; i < 26; i++) begin
      req_ready = tv[i].rr; resp_valid = tv[i].rv; resp_data = tv[i].rd;
      inst_ready = tv[i].ir; redirect_valid = tv[i].rdv; redirect_pc = tv[i].rpc;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_req_valid", i), req_valid, tv[i].e_reqv);
      chk($sformatf("vec%0d_req_addr", i), req_addr, tv[i].e_addr);
      chk($sformatf("vec%0d_inst_valid", i), inst_valid, tv[i].e_instv);
      chk($sformatf("vec%0d_inst", i), inst, tv[i].e_inst);
      chk($sformatf("vec%0d_inst_pc", i), inst_pc, tv[i].e_ipc);
      chk($sformatf("vec%0d_fetch_cnt", i), fetch_cnt, tv[i].e_cnt);
      if (i == 1) chk("wrap_inst_pc", w_inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      if (i == 2) begin
        chk("wrap_req_addr", w_req_addr, 64'h0);
        chk("wrap_fetch_cnt", w_fetch_cnt, 64'd1);
      end
    end

    // ---- reset asserted mid-transaction (request outstanding) ----
    req_ready = 1; resp_valid = 0; inst_ready = 0; redirect_valid = 0;
    @(posedge clk);
    #1;
    chk("mid_wait_req_valid", req_valid, 0);
    req_ready = 0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_fetch_cnt", fetch_cnt, 0);
    chk("async_rst_inst", inst, 0);
    chk("async_rst_req_addr", req_addr, 64'h8000_0000);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("after_rst_req_valid", req_valid, 1);
    chk("after_rst_req_addr", req_addr, 64'h8000_0000);

    // ---- misaligned redirect ----
    redirect_valid = 1; redirect_pc = 64'h8000_0002;
    @(posedge clk);
    #1;
`ifdef IFU_MISALIGN_CHECK_EN
    chk("mis_fault", fault, 1);
    chk("mis_req_valid", req_valid, 0);
    chk("mis_inst_valid", inst_valid, 0);
`else
    chk("mis_fault", fault, 0);
    chk("mis_req_valid", req_valid, 1);
    chk("mis_req_addr", req_addr, 64'h8000_0000);
`endif
    redirect_pc = 64'h8000_0010;
    @(posedge clk);
    #1;
    chk("align_fault", fault, 0);
    chk("align_req_valid", req_valid, 1);
    chk("align_req_addr", req_addr, 64'h8000_0010);
    redirect_valid = 0;

    // ---- randomized run against the reference model ----
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      req_ready      = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      rp = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
      redirect_pc = rp;
      resp_valid  = mem_busy && (mem_wait == 0);
      resp_data   = $urandom;
      @(posedge clk);
      model_step();
      #1;
      chk("rnd_req_valid", req_valid, !m_hold && !m_outst && !m_fault);
      chk("rnd_req_addr", req_addr, m_pc);
      chk("rnd_inst_valid", inst_valid, m_hold);
      chk("rnd_inst", inst, m_inst);
      chk("rnd_inst_pc", inst_pc, m_ipc);
      chk("rnd_fetch_cnt", fetch_cnt, m_cnt);
      chk("rnd_fault", fault, m_fault);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
